// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer that owns the HI/LO
// registers of the EX stage.
//   MUL/MADD : radix-2 shift-add on operand magnitudes, WIDTH cycles
//   DIV      : radix-2 restoring division, WIDTH cycles
//   then one FIX cycle applies sign correction / accumulation and commits.
// Ports:
//   clock_i, reset_i         clock (rising edge), async active-high reset
//   start_i, op_i, op_u_i    request valid, operation, 1 = unsigned
//   a_i, b_i                 operands (a_i is also the MTHI/MTLO source)
//   flush_i                  abort the in-flight operation
//   stall_o, busy_o, done_o  EX stall, unit not idle, commit pulse
//   hi_o, lo_o               architectural HI/LO registers

package muldiv_pkg;
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MUL  = 3'd1,
        OP_MADD = 3'd2,
        OP_DIV  = 3'd3,
        OP_MTHI = 3'd4,
        OP_MTLO = 3'd5
    } muldiv_op_t;
endpackage

module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = $clog2(WIDTH) + 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic             op_u_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    // Shared datapath: MUL keeps {partial product, multiplier}, DIV keeps
    // {partial remainder (WIDTH+1 bits), dividend/quotient}.
    logic [2*WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]       mb_q, mb_d;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]       a_q, a_d;       // raw dividend for divide-by-zero
    logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
    logic [2:0]             op_q, op_d;
    logic                   neg_q, neg_d;   // result sign
    logic                   dneg_q, dneg_d; // dividend sign (remainder sign)
    logic                   bz_q, bz_d;

    logic                   multi_req, a_neg, b_neg;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [WIDTH:0]         mul_sum, div_sh, div_diff, div_rem;
    logic                   div_ge;
    logic [2*WIDTH:0]       mul_next, div_next;
    logic [2*WIDTH-1:0]     prod, prod_fix, madd_sum;
    logic [WIDTH-1:0]       quo_fix, rem_fix;

    assign multi_req = start_i & ((op_i == OP_MUL) | (op_i == OP_MADD) | (op_i == OP_DIV));
    assign a_neg     = ~op_u_i & a_i[WIDTH-1];
    assign b_neg     = ~op_u_i & b_i[WIDTH-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;

    // Shift-add step: add the multiplicand when the current multiplier bit
    // is set, then shift the whole accumulator right by one.
    assign mul_sum  = acc_q[2*WIDTH:WIDTH] + {1'b0, (acc_q[0] ? mb_q : '0)};
    assign mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: shift in the next dividend bit, subtract if it fits.
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, mb_q};
    assign div_ge   = (div_sh >= {1'b0, mb_q});
    assign div_rem  = div_ge ? div_diff : div_sh;
    assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

    assign prod     = acc_q[2*WIDTH-1:0];
    assign prod_fix = neg_q ? -prod : prod;
    assign madd_sum = {hi_q, lo_q} + prod_fix;
    assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = dneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mb_d    = mb_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        neg_d   = neg_q;
        dneg_d  = dneg_q;
        bz_d    = bz_q;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    if (multi_req) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        op_d    = op_i;
                        neg_d   = a_neg ^ b_neg;
                        dneg_d  = a_neg;
                        bz_d    = (b_i == '0);
                        a_d     = a_i;
                        if (op_i == OP_DIV) begin
                            acc_d = {{(WIDTH+1){1'b0}}, a_mag};
                            mb_d  = b_mag;
                        end else begin
                            acc_d = {{(WIDTH+1){1'b0}}, b_mag};
                            mb_d  = a_mag;
                        end
                    end else if (op_i == OP_MTHI) begin
                        hi_d = a_i;
                    end else if (op_i == OP_MTLO) begin
                        lo_d = a_i;
                    end
                end
            end
            S_RUN: begin
                acc_d = (op_q == OP_DIV) ? div_next : mul_next;
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    done_o = 1'b1;
                    if (op_q == OP_DIV) begin
                        if (bz_q) begin
                            hi_d = a_q;
                            lo_d = '1;
                        end else begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end
                    end else if (op_q == OP_MADD) begin
                        {hi_d, lo_d} = madd_sum;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mb_q    <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= OP_NONE;
            neg_q   <= 1'b0;
            dneg_q  <= 1'b0;
            bz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mb_q    <= mb_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            dneg_q  <= dneg_d;
            bz_q    <= bz_d;
        end
    end

    // Stall drops in FIX so the pipeline advances on the commit edge.
    assign stall_o = (multi_req & (state_q == S_IDLE)) | (state_q == S_RUN);
    assign busy_o  = (state_q != S_IDLE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic         op_u  = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         flush = 1'b0;
    logic         stall, busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_hl = '0;
    logic        exp_stall = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clock_i(clock), .reset_i(reset), .start_i(start), .op_i(op),
        .op_u_i(op_u), .a_i(a), .b_i(b), .flush_i(flush),
        .stall_o(stall), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference results straight from the arithmetic definition.
    function automatic logic [63:0] model(input logic [2:0] o, input logic u,
                                          input logic [31:0] av, input logic [31:0] bv,
                                          input logic [63:0] hl);
        longint      sa, sb, q, r;
        logic [63:0] p, qq, rr;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (u) p = {32'b0, av} * {32'b0, bv};
        else   p = 64'(sa * sb);
        case (o)
            OP_MUL:  return p;
            OP_MADD: return hl + p;
            OP_DIV: begin
                if (bv == 0) return {av, 32'hFFFF_FFFF};
                if (u) return {av % bv, av / bv};
                q = sa / sb;
                r = sa % sb;
                qq = 64'(q);
                rr = 64'(r);
                return {rr[31:0], qq[31:0]};
            end
            OP_MTHI: return {av, hl[31:0]};
            OP_MTLO: return {hl[63:32], av};
            default: return hl;
        endcase
    endfunction

    always @(negedge clock) begin
        chk("stall", 64'(stall), 64'(exp_stall));
        chk("busy",  64'(busy),  64'(exp_busy));
        chk("done",  64'(done),  64'(exp_done));
        chk("hi",    64'(hi),    64'(model_hl[63:32]));
        chk("lo",    64'(lo),    64'(model_hl[31:0]));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_exp(input logic s, input logic bz, input logic d);
        exp_stall = s;
        exp_busy  = bz;
        exp_done  = d;
    endtask

    // Issue one instruction at the start of a cycle; fl_c / rs_c select the
    // cycle (relative to start) at which flush or reset hits, -1 for none.
    task automatic run_op(input logic [2:0] o, input logic u, input logic [31:0] av,
                          input logic [31:0] bv, input int fl_c, input int rs_c);
        logic [63:0] res;
        res   = model(o, u, av, bv, model_hl);
        start = 1'b1; op = o; op_u = u; a = av; b = bv;
        if (o == OP_MUL || o == OP_MADD || o == OP_DIV) begin
            for (int c = 0; c <= W + 1; c++) begin
                if (c == rs_c) begin
                    reset = 1'b1; start = 1'b0; model_hl = '0;
                    set_exp(1'b0, 1'b0, 1'b0);
                    step();
                    reset = 1'b0;
                    return;
                end
                flush = (c == fl_c);
                set_exp(c <= W, c >= 1, (c == W + 1) && (c != fl_c));
                step();
                if (c == fl_c) begin
                    flush = 1'b0; start = 1'b0;
                    set_exp(1'b0, 1'b0, 1'b0);
                    return;
                end
            end
        end else begin
            set_exp(1'b0, 1'b0, 1'b0);
            step();
        end
        model_hl = res;
        start = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          rf;

        // Model pins against hand-computed values.
        chk("model_smul", model(OP_MUL, 1'b0, 32'hFFFF_FFFD, 32'd5, 64'd0), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("model_sdiv", model(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 64'd0), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_ovf",  model(OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0), 64'h0000_0000_8000_0000);

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        step();

        run_op(OP_MUL, 1'b0, 32'hFFFF_FFFD, 32'd5, -1, -1);
        chk("smul_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("smul_lo", 64'(lo), 64'hFFFF_FFF1);
        run_op(OP_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        chk("umul_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("umul_lo", 64'(lo), 64'h0000_0001);
        run_op(OP_MADD, 1'b1, 32'd1, 32'd1, -1, -1);
        chk("madd_lo", 64'(lo), 64'h0000_0002);
        run_op(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, -1, -1);
        chk("sdiv_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("sdiv_hi", 64'(hi), 64'hFFFF_FFFF);
        run_op(OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        chk("ovf_lo", 64'(lo), 64'h8000_0000);
        chk("ovf_hi", 64'(hi), 64'h0);
        run_op(OP_DIV, 1'b1, 32'd7, 32'd0, -1, -1);
        chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("dz_hi", 64'(hi), 64'd7);
        run_op(OP_MTHI, 1'b0, 32'h1234_5678, 32'd0, -1, -1);
        run_op(OP_MTLO, 1'b0, 32'h9ABC_DEF0, 32'd0, -1, -1);
        chk("mt_hi", 64'(hi), 64'h1234_5678);
        chk("mt_lo", 64'(lo), 64'h9ABC_DEF0);
        run_op(OP_MUL, 1'b0, 32'd1000, 32'd3, 10, -1);
        run_op(OP_DIV, 1'b1, 32'd100, 32'd7, -1, -1);
        chk("fl_div_lo", 64'(lo), 64'd14);
        chk("fl_div_hi", 64'(hi), 64'd2);
        run_op(OP_DIV, 1'b0, 32'd12345, 32'd17, -1, 20);
        chk("rst_hi", 64'(hi), 64'h0);
        run_op(OP_MTLO, 1'b0, 32'hCAFE_F00D, 32'd0, -1, -1);
        run_op(OP_MUL, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, -1, -1);
        chk("post_rst_lo", 64'(lo), 64'd6);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 10))
                0, 1, 2: ro = OP_MUL;
                3, 4:    ro = OP_MADD;
                5, 6, 7: ro = OP_DIV;
                8:       ro = OP_MTHI;
                9:       ro = OP_MTLO;
                default: ro = 3'($urandom_range(6, 7));
            endcase
            ra = pick();
            rb = pick();
            rf = ($urandom_range(0, 9) == 0) ? $urandom_range(0, W + 1) : -1;
            run_op(ro, 1'($urandom_range(0, 1)), ra, rb, rf, -1);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the architectural HI/LO registers for the EX stage.
- Executes MUL/MADD as radix-2 shift-add and DIV as radix-2 restoring division: one iteration per cycle, one sign-fix/accumulate cycle.
- Drives the EX stall while busy and returns HI/LO for MFHI/MFLO.
- Replaces the single-expression behavioural mul/div model with a synthesizable, fixed-latency unit.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_WIDTH, $clog2(WIDTH)+1: iteration counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request valid. Held high with op/op_u/a/b stable until done.
- op  in  muldiv_op_t  OP_MUL, OP_MADD, OP_DIV, OP_MTHI, OP_MTLO act. All other values mean no operation.
- op_u  in  1  1 = unsigned, 0 = signed (two's complement).
- a  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- b  in  WIDTH  multiplier / divisor.
- flush  in  1  abort any in-flight operation.
- stall  out  1  hold the EX stage.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse; the result is committed at the end of this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state=IDLE; hi=lo=0; count=0; stall=busy=done=0. Reset mid-operation discards the operation.
- States and transitions:
  - IDLE -> RUN when start is high and op is MUL, MADD or DIV.
  - RUN -> FIX after WIDTH iterations.
  - FIX -> IDLE unconditionally.
- Operand capture (IDLE->RUN edge):
  - Latch |a| and |b| when signed, raw values when unsigned.
  - Latch the result sign and the dividend sign.
  - Latch the op and whether b==0.
- Iteration (RUN, one per cycle, count 0..WIDTH-1):
  - MUL/MADD: 2*WIDTH accumulator shift-add on magnitudes.
  - DIV: restoring step producing one quotient bit per cycle; the partial remainder is WIDTH+1 bits.
- FIX cycle (done=1):
  - MUL: product negated (2*WIDTH bits) if signed and a[31]^b[31].
  - MADD: fixed product added to {hi,lo}, 2*WIDTH-bit wrap, no overflow flag.
  - DIV: quotient negated if signed and signs differ. Remainder takes the dividend sign (truncating division).
  - {hi,lo} written at the end of FIX: DIV writes hi=remainder, lo=quotient.
- Divide by zero: lo=all-ones, hi=a as captured (original a, no sign correction). Same latency.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap).
- Latency: start seen in IDLE at cycle 0 -> RUN cycles 1..WIDTH -> FIX at cycle WIDTH+1 with done=1 -> hi/lo new from cycle WIDTH+2.
- stall = (start & op in {MUL,MADD,DIV} & state==IDLE) | (state==RUN). So stall is high in cycles 0..WIDTH and low in FIX, letting the pipeline advance at that edge.
- busy is high in RUN and FIX.
- MTHI/MTLO in IDLE: hi (resp. lo) <= a at the next edge. No stall, no done, no state change.
- start while busy: no new capture.
- flush:
  - Forces IDLE at the next edge; hi/lo unchanged; done suppressed.
  - Flush in FIX has priority over the commit.
  - Flush together with start in IDLE: start ignored.
- After FIX, the requester deasserts start or presents the next instruction. Back-to-back multicycle ops are accepted from IDLE; there is one IDLE cycle between operations.
- hi/lo are direct register outputs (MFHI/MFLO read them combinationally). The pipeline guarantees no MFHI/MFLO issues while busy.

Test Plan:
- Signed MUL, a=0xFFFFFFFD (-3), b=5 -> stall high cycles 0..32, done at cycle 33, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Unsigned MUL, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MADD unsigned, a=1, b=1 -> hi=0xFFFFFFFE, lo=0x00000002.
- Signed DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. Unsigned 7/0 -> lo=0xFFFFFFFF, hi=7.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 in consecutive cycles -> hi/lo updated next edge each, stall never high.
- MUL started, flush at cycle 10 -> IDLE at cycle 11, no done, hi/lo unchanged; a new DIV started at cycle 11 completes normally at cycle 44.
- Reset asserted at cycle 20 of a DIV -> immediately busy=stall=0, hi=lo=0. After release, an MTLO followed by a signed MUL works correctly.
